bp_fe_queue_rolly_multi: RTL



---
 rtl/bp_fe_queue_rolly_multi.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bp_fe_queue_rolly_multi.sv
// Speculative FE->BE queue with separate write, speculative-read and commit pointers.
// Latency: an enqueued entry shows on v_o/data_o one cycle later; a commit frees space one cycle later.
// Backpressure: ready_o drops when the write and commit pointers show a full queue; v_i is legal only while ready_o=1.
//
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   data_i, v_i, ready_o  enqueue side (ready-then-valid)
//   data_o, v_o, yumi_i   speculative read side (yumi_i consumes data_o)
//   deq_cnt_i             entries to commit this cycle (0..deq_max_p)
//   roll_v_i              rewind the read pointer to the commit pointer
//   clr_v_i               discard every entry, keeping a same-cycle enqueue as already consumed
//   occ_o, spec_o         wptr-cptr and rptr-cptr
//   err_o                 sticky protocol error; real logic only when BP_FE_QUEUE_ROLLY_CHECK_EN is defined
module bp_fe_queue_rolly_multi #(
  parameter int width_p   = 64,
  parameter int els_p     = 8,
  parameter int deq_max_p = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [width_p-1:0]               data_i,
  input  logic                             v_i,
  output logic                             ready_o,
  output logic [width_p-1:0]               data_o,
  output logic                             v_o,
  input  logic                             yumi_i,
  input  logic [$clog2(deq_max_p+1)-1:0]   deq_cnt_i,
  input  logic                             roll_v_i,
  input  logic                             clr_v_i,
  output logic [$clog2(els_p+1)-1:0]       occ_o,
  output logic [$clog2(els_p+1)-1:0]       spec_o,
  output logic                             err_o
);

  localparam int idx_w = $clog2(els_p);
  localparam int ptr_w = idx_w + 1;

  logic [width_p-1:0] mem [els_p];

  logic [ptr_w-1:0] wptr, rptr, cptr;
  logic [ptr_w-1:0] wptr_n, rptr_n, cptr_n;
  logic [ptr_w-1:0] occ_d, spec_d, commit_req, commit_amt;
  logic             full, enq, yumi_ok;

  // Full when indices match but wrap bits differ; equal pointers mean empty.
  assign full    = (wptr[idx_w-1:0] == cptr[idx_w-1:0]) && (wptr[ptr_w-1] != cptr[ptr_w-1]);
  assign ready_o = ~full;
  assign v_o     = (rptr != wptr);
  assign data_o  = mem[rptr[idx_w-1:0]];

  // With power-of-two els_p the occupancy width equals the pointer width.
  assign occ_d  = wptr - cptr;
  assign spec_d = rptr - cptr;
  assign occ_o  = occ_d;
  assign spec_o = spec_d;

  assign commit_req = ptr_w'(deq_cnt_i);

`ifdef BP_FE_QUEUE_ROLLY_CHECK_EN
  logic err_q;
  logic wr_err, rd_err, cm_err;

  // A yumi that is overridden by clear or roll is harmless, so it is not flagged.
  assign wr_err = v_i & full;
  assign rd_err = yumi_i & ~v_o & ~clr_v_i & ~roll_v_i;
  assign cm_err = (commit_req > spec_d) & ~clr_v_i;

  assign enq        = v_i & ~full;
  assign yumi_ok    = yumi_i & v_o;
  assign commit_amt = cm_err ? '0 : commit_req;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q <= 1'b0;
    end else if (wr_err | rd_err | cm_err) begin
      err_q <= 1'b1;
    end
  end
`else
  assign enq        = v_i & ~full;
  assign yumi_ok    = yumi_i;
  assign commit_amt = commit_req;
  assign err_o      = 1'b0;
`endif

  always_comb begin
    wptr_n = wptr + ptr_w'(enq);
    cptr_n = cptr + commit_amt;
    rptr_n = rptr;
    if (clr_v_i) begin
      // Same-cycle write is kept in storage but counts as read and committed.
      rptr_n = wptr_n;
      cptr_n = wptr_n;
    end else if (roll_v_i) begin
      // Rewind lands after anything committed in this same cycle.
      rptr_n = cptr_n;
    end else if (yumi_ok) begin
      rptr_n = rptr + ptr_w'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  // Storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wptr[idx_w-1:0]] <= data_i;
    end
  end

endmodule
